// File: rtl/hdlc_rx_deframer.sv
// HDLC receive channel: flag hunt, zero removal, abort detection, LSB-first byte assembly and
// single-frame buffer with host readout. Define HDLC_RX_FCS_CHECK_EN to enable the CRC-16 FCS check.
module hdlc_rx_deframer #(
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned MIN_FRAME = 4,
    parameter int unsigned SIZE_W    = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx,
    input  logic              RxEN,
    input  logic              RdBuff,
    input  logic              Drop,
    output logic [7:0]        DataOut,
    output logic              Ready,
    output logic [SIZE_W-1:0] FrameSize,
    output logic              Overflow,
    output logic              AbortSignal,
    output logic              FrameError,
    output logic              FCSerr
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [SIZE_W-1:0] DepthCnt = SIZE_W'(DEPTH);
    localparam logic [SIZE_W-1:0] MinCnt   = SIZE_W'(MIN_FRAME);

    typedef enum logic [1:0] {StIdle, StSync, StRecv, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        win_q, win_d;
    logic [3:0]        fill_q, fill_d;
    logic [2:0]        ones_q, ones_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        asm_q, asm_d;
    logic [SIZE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              ready_q, ready_d;
    logic              ovf_q, ovf_d;
    logic              abort_q, abort_d;
    logic              ferr_q, ferr_d;
`ifdef HDLC_RX_FCS_CHECK_EN
    logic [15:0]       crc_q, crc_d, crc_v;
    logic              crc_fb;
    logic              fcs_err_q, fcs_err_d;
`endif

    logic [7:0]        mem_q [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [7:0]        mem_wdata;

    logic [7:0]        win_n;
    logic              is_flag, is_abort, dbit, dvld, start, frm;
    logic [2:0]        ones_v, bit_v;
    logic [7:0]        asm_v;
    logic [SIZE_W-1:0] cnt_v, size_v;
    logic              ovf_v;

    always_comb begin
        win_n    = {Rx, win_q[7:1]};
        is_flag  = (win_n == 8'h7E);
        is_abort = &win_n[7:1];
        dbit     = win_q[0];
        // A bit leaving the window is data only once 8 bits have entered since the last flag
        dvld     = (fill_q == 4'd8);
        start    = (state_q == StSync) && dvld;
        frm      = (state_q == StRecv) || start;
        size_v   = byte_cnt_q - SIZE_W'(2);

        ones_v   = start ? 3'd0 : ones_q;
        bit_v    = start ? 3'd0 : bit_cnt_q;
        cnt_v    = start ? '0 : byte_cnt_q;
        ovf_v    = start ? 1'b0 : ovf_q;
        asm_v    = asm_q;
`ifdef HDLC_RX_FCS_CHECK_EN
        crc_v     = start ? 16'h0000 : crc_q;
        crc_fb    = 1'b0;
        crc_d     = crc_q;
        fcs_err_d = fcs_err_q;
`endif
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h00;

        state_d    = state_q;
        win_d      = win_q;
        fill_d     = fill_q;
        ones_d     = ones_q;
        bit_cnt_d  = bit_cnt_q;
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        ready_d    = ready_q;
        ovf_d      = ovf_q;
        abort_d    = 1'b0;
        ferr_d     = 1'b0;

        if (RxEN) begin
            win_d  = win_n;
            fill_d = is_flag ? 4'd0 : (dvld ? fill_q : fill_q + 4'd1);
            if (frm) begin
                if (ones_v == 3'd5 && !dbit) begin
                    ones_v = 3'd0;
                end else begin
                    ones_v = dbit ? ((ones_v == 3'd7) ? 3'd7 : ones_v + 3'd1) : 3'd0;
                    asm_v  = {dbit, asm_v[7:1]};
`ifdef HDLC_RX_FCS_CHECK_EN
                    // Reflected bit-serial form of x^16+x^15+x^2+1
                    crc_fb = crc_v[0] ^ dbit;
                    crc_v  = {1'b0, crc_v[15:1]} ^ (crc_fb ? 16'hA001 : 16'h0000);
`endif
                    if (bit_v == 3'd7) begin
                        if (cnt_v == DepthCnt) begin
                            ovf_v = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_addr  = cnt_v[AW-1:0];
                            mem_wdata = asm_v;
                            cnt_v     = cnt_v + SIZE_W'(1);
                        end
                    end
                    bit_v = bit_v + 3'd1;
                end
                ones_d     = ones_v;
                bit_cnt_d  = bit_v;
                asm_d      = asm_v;
                byte_cnt_d = cnt_v;
                ovf_d      = ovf_v;
`ifdef HDLC_RX_FCS_CHECK_EN
                crc_d      = crc_v;
`endif
                if (is_abort) begin
                    abort_d = (state_q == StRecv);
                    ovf_d   = 1'b0;
                    state_d = StIdle;
                end else if (is_flag) begin
                    if (bit_v != 3'd0 || cnt_v < MinCnt) begin
                        ferr_d  = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = StSync;
                    end else begin
                        ready_d = 1'b1;
                        state_d = StDone;
`ifdef HDLC_RX_FCS_CHECK_EN
                        fcs_err_d = (crc_v != 16'h0000);
`endif
                    end
                end else begin
                    state_d = StRecv;
                end
            end else if (state_q == StIdle && is_flag) begin
                state_d = StSync;
            end else if (state_q == StSync && is_abort) begin
                state_d = StIdle;
            end
        end

        if (state_q == StDone) begin
            if (Drop || (RdBuff && SIZE_W'(rd_ptr_q) == size_v - SIZE_W'(1))) begin
                ready_d    = 1'b0;
                rd_ptr_d   = '0;
                ovf_d      = 1'b0;
                byte_cnt_d = '0;
                state_d    = StSync;
`ifdef HDLC_RX_FCS_CHECK_EN
                fcs_err_d  = 1'b0;
`endif
            end else if (RdBuff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= StIdle;
            win_q      <= 8'h00;
            fill_q     <= 4'd0;
            ones_q     <= 3'd0;
            bit_cnt_q  <= 3'd0;
            asm_q      <= 8'h00;
            byte_cnt_q <= '0;
            rd_ptr_q   <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            abort_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef HDLC_RX_FCS_CHECK_EN
            crc_q      <= 16'h0000;
            fcs_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            fill_q     <= fill_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            abort_q    <= abort_d;
            ferr_q     <= ferr_d;
`ifdef HDLC_RX_FCS_CHECK_EN
            crc_q      <= crc_d;
            fcs_err_q  <= fcs_err_d;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign DataOut     = ready_q ? mem_q[rd_ptr_q] : 8'h00;
    assign Ready       = ready_q;
    assign FrameSize   = ready_q ? size_v : '0;
    assign Overflow    = ovf_q;
    assign AbortSignal = abort_q;
    assign FrameError  = ferr_q;
`ifdef HDLC_RX_FCS_CHECK_EN
    assign FCSerr      = fcs_err_q;
`else
    assign FCSerr      = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: table of frames plus hand-written abort, short-frame,
// overflow/drop, RxEN-gap, FCS-corruption and mid-frame reset sequences.
module tb_hdlc_rx_deframer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rxen, rx_a, rd_a, drop_a, rx_b, rd_b, drop_b;
    logic [7:0] dout_a, dout_b;
    logic [7:0] size_a;
    logic [4:0] size_b;
    logic       ready_a, ovf_a, abort_a, ferr_a, fcserr_a;
    logic       ready_b, ovf_b, abort_b, ferr_b, fcserr_b;

    hdlc_rx_deframer #(.DEPTH(128), .MIN_FRAME(4)) u_dut (
        .Clk(clk), .Rst(rst_n), .Rx(rx_a), .RxEN(rxen), .RdBuff(rd_a), .Drop(drop_a),
        .DataOut(dout_a), .Ready(ready_a), .FrameSize(size_a), .Overflow(ovf_a),
        .AbortSignal(abort_a), .FrameError(ferr_a), .FCSerr(fcserr_a)
    );

    hdlc_rx_deframer #(.DEPTH(16), .MIN_FRAME(4)) u_dut16 (
        .Clk(clk), .Rst(rst_n), .Rx(rx_b), .RxEN(rxen), .RdBuff(rd_b), .Drop(drop_b),
        .DataOut(dout_b), .Ready(ready_b), .FrameSize(size_b), .Overflow(ovf_b),
        .AbortSignal(abort_b), .FrameError(ferr_b), .FCSerr(fcserr_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int abort_cnt = 0;
    int ferr_cnt = 0;
    logic        sel_b;
    logic        gap_en;
    int          tx_ones;
    logic [15:0] fcs_xor;
    logic [7:0]  txq [$];

    typedef struct packed {
        logic [23:0] data;
        logic [7:0]  n;
        logic        exp_ready;
        logic [7:0]  exp_size;
    } vec_t;
    vec_t vecs [5];

    // Pulse outputs counted per cycle high, so a one-cycle pulse adds exactly one
    always @(negedge clk) begin
        if (abort_a) abort_cnt++;
        if (ferr_a) ferr_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (gap_en) begin
            rxen = 1'b0;
            rx_a = 1'($urandom_range(0, 1));
            rx_b = 1'($urandom_range(0, 1));
            tick();
            tick();
        end
        rxen = 1'b1;
        if (sel_b) begin
            rx_b = b;
            rx_a = 1'b1;
        end else begin
            rx_a = b;
            rx_b = 1'b1;
        end
        tick();
        rxen = 1'b0;
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (b[i]) tx_ones++;
            else tx_ones = 0;
            if (tx_ones == 5) begin
                send_bit(1'b0);
                tx_ones = 0;
            end
        end
    endtask

    function automatic logic [15:0] crc16_arc();
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (txq[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ txq[k][i];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic send_frame();
        logic [15:0] fcs;
        fcs = crc16_arc() ^ fcs_xor;
        tx_ones = 0;
        send_flag();
        foreach (txq[k]) send_byte(txq[k]);
        send_byte(fcs[7:0]);
        send_byte(fcs[15:8]);
        send_flag();
    endtask

    task automatic read_frame(input string tag);
        for (int k = 0; k < txq.size(); k++) begin
            check($sformatf("%s_data%0d", tag, k), dout_a, txq[k]);
            check($sformatf("%s_ready_before_rd%0d", tag, k), ready_a, 1);
            rd_a = 1'b1;
            tick();
            rd_a = 1'b0;
        end
        check($sformatf("%s_ready_after_reads", tag), ready_a, 0);
        check($sformatf("%s_size_after_reads", tag), size_a, 0);
    endtask

    initial begin
        int e_ferr, e_abort;

        vecs[0] = '{data: 24'h000FA5, n: 8'd2, exp_ready: 1'b1, exp_size: 8'd2};
        vecs[1] = '{data: 24'h003EFF, n: 8'd2, exp_ready: 1'b1, exp_size: 8'd2};
        vecs[2] = '{data: 24'h00007E, n: 8'd1, exp_ready: 1'b0, exp_size: 8'd0};
        vecs[3] = '{data: 24'h7EFF00, n: 8'd3, exp_ready: 1'b1, exp_size: 8'd3};
        vecs[4] = '{data: 24'h00AA55, n: 8'd2, exp_ready: 1'b1, exp_size: 8'd2};

        rst_n = 1'b0; rxen = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        rd_a = 1'b0; drop_a = 1'b0; rd_b = 1'b0; drop_b = 1'b0;
        sel_b = 1'b0; gap_en = 1'b0; fcs_xor = 16'h0000; tx_ones = 0;
        tick(); tick(); tick();
        check("rst_ready", ready_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_size", size_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_fcserr", fcserr_a, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", ready_a, 0);
        check("post_rst_abort", abort_a, 0);
        check("post_rst_ferr", ferr_a, 0);
        check("post_rst_ready16", ready_b, 0);

        for (int v = 0; v < 5; v++) begin
            txq.delete();
            for (int k = 0; k < int'(vecs[v].n); k++) txq.push_back(vecs[v].data[8*k +: 8]);
            e_ferr = ferr_cnt;
            send_frame();
            tick();
            check($sformatf("v%0d_ready", v), ready_a, vecs[v].exp_ready);
            check($sformatf("v%0d_size", v), size_a, vecs[v].exp_size);
            check($sformatf("v%0d_ferr_pulses", v), ferr_cnt - e_ferr, vecs[v].exp_ready ? 0 : 1);
            check($sformatf("v%0d_fcserr", v), fcserr_a, 0);
            if (vecs[v].exp_ready) read_frame($sformatf("v%0d", v));
        end

        // Strobes while nothing is ready must not move the read pointer; RxEN gaps freeze the path
        rd_a = 1'b1;
        tick(); tick(); tick();
        rd_a = 1'b0;
        txq.delete();
        txq.push_back(8'hC3);
        txq.push_back(8'h5A);
        e_ferr = ferr_cnt;
        e_abort = abort_cnt;
        gap_en = 1'b1;
        send_frame();
        gap_en = 1'b0;
        tick();
        check("gap_ready", ready_a, 1);
        check("gap_size", size_a, 2);
        check("gap_no_ferr", ferr_cnt - e_ferr, 0);
        check("gap_no_abort", abort_cnt - e_abort, 0);
        read_frame("gap");

        // Abort: flag, 12 data bits, seven 1s
        e_abort = abort_cnt;
        e_ferr = ferr_cnt;
        send_flag();
        for (int i = 0; i < 12; i++) send_bit((i % 2) == 0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        tick(); tick();
        check("abort_pulses", abort_cnt - e_abort, 1);
        check("abort_ready", ready_a, 0);
        check("abort_no_ferr", ferr_cnt - e_ferr, 0);
        txq.delete();
        txq.push_back(8'h12);
        txq.push_back(8'h34);
        send_frame();
        tick();
        check("post_abort_ready", ready_a, 1);
        check("post_abort_size", size_a, 2);
        read_frame("post_abort");

        // Closing flag after 19 data bits
        e_ferr = ferr_cnt;
        send_flag();
        for (int i = 0; i < 19; i++) send_bit((i % 2) == 0);
        send_flag();
        tick(); tick();
        check("bits19_ferr_pulses", ferr_cnt - e_ferr, 1);
        check("bits19_ready", ready_a, 0);

        // Overflow on the 16-byte instance: 18 payload + 2 FCS bytes
        sel_b = 1'b1;
        txq.delete();
        for (int k = 0; k < 18; k++) txq.push_back(8'((k * 13 + 1) % 256));
        send_frame();
        tick();
        check("ovf_ready16", ready_b, 1);
        check("ovf_flag16", ovf_b, 1);
        check("ovf_size16", size_b, 14);
        check("ovf_byte0", dout_b, txq[0]);
        rd_b = 1'b1;
        tick();
        rd_b = 1'b0;
        check("ovf_byte1", dout_b, txq[1]);
        drop_b = 1'b1;
        rd_b = 1'b1;
        tick();
        drop_b = 1'b0;
        rd_b = 1'b0;
        check("drop_ready16", ready_b, 0);
        check("drop_ovf16", ovf_b, 0);
        check("drop_size16", size_b, 0);
        sel_b = 1'b0;

`ifdef HDLC_RX_FCS_CHECK_EN
        txq.delete();
        txq.push_back(8'hA5);
        txq.push_back(8'h0F);
        fcs_xor = 16'h0001;
        send_frame();
        fcs_xor = 16'h0000;
        tick();
        check("badfcs_ready", ready_a, 1);
        check("badfcs_fcserr", fcserr_a, 1);
        check("badfcs_size", size_a, 2);
        drop_a = 1'b1;
        tick();
        drop_a = 1'b0;
        check("badfcs_drop_ready", ready_a, 0);
        check("badfcs_drop_fcserr", fcserr_a, 0);
`endif

        // Reset asserted mid-frame while a frame is held
        txq.delete();
        txq.push_back(8'h11);
        txq.push_back(8'h22);
        send_frame();
        tick();
        check("prerst_ready", ready_a, 1);
        send_flag();
        for (int i = 0; i < 5; i++) send_bit(i == 2);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready_a, 0);
        check("midrst_size", size_a, 0);
        check("midrst_dout", dout_a, 0);
        check("midrst_ovf", ovf_a, 0);
        check("midrst_fcserr", fcserr_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        txq.delete();
        txq.push_back(8'h99);
        txq.push_back(8'h66);
        send_frame();
        tick();
        check("final_ready", ready_a, 1);
        check("final_size", size_a, 2);
        read_frame("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
